// File: rtl/frame_stack.sv
// Value stack plus call-frame stack with frame-relative locals for a
// WebAssembly-style execution core. Single-cycle ops with registered outputs.
module frame_stack #(
   parameter int WIDTH  = 32,
   parameter int DEPTH  = 8,
   parameter int FRAMES = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [2:0]        op,
   input  logic [WIDTH-1:0]  data,
   input  logic [DEPTH-1:0]  arg,
   input  logic              keep,
   output logic [WIDTH-1:0]  tos,
   output logic [1:0]        status,
   output logic [DEPTH:0]    index,
   output logic [FRAMES:0]   frame_depth
);

   typedef enum logic [2:0] {
      OP_NONE, OP_PUSH, OP_POP, OP_REPLACE, OP_CALL, OP_RETURN, OP_GET, OP_SET
   } op_e;

   typedef enum logic [1:0] {
      ST_NONE, ST_EMPTY, ST_UNDERFLOW, ST_OVERFLOW
   } status_e;

   logic [WIDTH-1:0] r_mem    [2**DEPTH];
   logic [DEPTH:0]   r_frames [2**FRAMES];

   logic [DEPTH:0]   r_index;
   logic [DEPTH:0]   r_base;
   logic [FRAMES:0]  r_fdepth;
   logic [WIDTH-1:0] r_tos;
   status_e          r_status;

   logic [DEPTH:0]    w_arg_ext;
   logic [DEPTH:0]    w_local;
   logic [DEPTH:0]    w_avail;
   logic [DEPTH:0]    w_old_base;
   logic [DEPTH-1:0]  w_top_addr;
   logic [DEPTH-1:0]  w_sec_addr;
   logic [DEPTH-1:0]  w_local_addr;
   logic [DEPTH-1:0]  w_below_addr;
   logic [FRAMES-1:0] w_fpop_addr;
   logic              w_full;
   logic              w_frames_full;

   logic [DEPTH:0]    w_nxt_index;
   logic [DEPTH:0]    w_nxt_base;
   logic [FRAMES:0]   w_nxt_fdepth;
   logic [WIDTH-1:0]  w_nxt_tos;
   status_e           w_nxt_status;
   logic              w_under;
   logic              w_over;
   logic              w_force_none;
   logic              w_mem_we;
   logic [DEPTH-1:0]  w_mem_addr;
   logic [WIDTH-1:0]  w_mem_wdata;
   logic              w_frm_we;

   // base+arg is kept at DEPTH+1 bits so an out-of-frame offset never wraps.
   assign w_arg_ext     = {1'b0, arg};
   assign w_local       = r_base + w_arg_ext;
   assign w_avail       = r_index - r_base;
   assign w_local_addr  = w_local[DEPTH-1:0];
   assign w_top_addr    = r_index[DEPTH-1:0] - DEPTH'(1);
   assign w_sec_addr    = r_index[DEPTH-1:0] - DEPTH'(2);
   assign w_below_addr  = r_base[DEPTH-1:0] - DEPTH'(1);
   assign w_fpop_addr   = r_fdepth[FRAMES-1:0] - FRAMES'(1);
   assign w_old_base    = r_frames[w_fpop_addr];
   assign w_full        = r_index[DEPTH];
   assign w_frames_full = r_fdepth[FRAMES];

   // NOTE: every comb output gets a default first so no path infers a latch.
   always_comb begin
      w_nxt_index  = r_index;
      w_nxt_base   = r_base;
      w_nxt_fdepth = r_fdepth;
      w_nxt_tos    = r_tos;
      w_under      = 1'b0;
      w_over       = 1'b0;
      w_force_none = 1'b0;
      w_mem_we     = 1'b0;
      w_mem_addr   = w_top_addr;
      w_mem_wdata  = data;
      w_frm_we     = 1'b0;

      unique case (op_e'(op))
         OP_PUSH: begin
            if (w_full) w_over = 1'b1;
            else begin
               w_mem_we    = 1'b1;
               w_mem_addr  = r_index[DEPTH-1:0];
               w_nxt_index = r_index + 1'b1;
               w_nxt_tos   = data;
            end
         end
         OP_POP: begin
            if (r_index <= r_base) w_under = 1'b1;
            else begin
               w_nxt_index = r_index - 1'b1;
               if (w_nxt_index > r_base) w_nxt_tos = r_mem[w_sec_addr];
            end
         end
         OP_REPLACE: begin
            if (r_index <= r_base) w_under = 1'b1;
            else begin
               w_mem_we     = 1'b1;
               w_nxt_tos    = data;
               w_force_none = 1'b1;
            end
         end
         OP_CALL: begin
            if (w_frames_full)           w_over = 1'b1;
            else if (w_avail < w_arg_ext) w_under = 1'b1;
            else begin
               w_frm_we     = 1'b1;
               w_nxt_base   = r_index - w_arg_ext;
               w_nxt_fdepth = r_fdepth + 1'b1;
            end
         end
         OP_RETURN: begin
            if (r_fdepth == '0)                 w_under = 1'b1;
            else if (keep && r_index == r_base) w_under = 1'b1;
            else begin
               if (keep) begin
                  w_mem_we    = 1'b1;
                  w_mem_addr  = r_base[DEPTH-1:0];
                  w_mem_wdata = r_tos;
                  w_nxt_index = r_base + 1'b1;
               end else begin
                  w_nxt_index = r_base;
                  if (r_base > w_old_base) w_nxt_tos = r_mem[w_below_addr];
               end
               w_nxt_base   = w_old_base;
               w_nxt_fdepth = r_fdepth - 1'b1;
            end
         end
         OP_GET: begin
            if (w_local >= r_index) w_under = 1'b1;
            else if (w_full)        w_over  = 1'b1;
            else begin
               w_mem_we    = 1'b1;
               w_mem_addr  = r_index[DEPTH-1:0];
               w_mem_wdata = r_mem[w_local_addr];
               w_nxt_index = r_index + 1'b1;
               w_nxt_tos   = r_mem[w_local_addr];
            end
         end
         OP_SET: begin
            if (r_index <= r_base)                         w_under = 1'b1;
            else if (w_local >= r_index - (DEPTH+1)'(1))   w_under = 1'b1;
            else begin
               w_mem_we    = 1'b1;
               w_mem_addr  = w_local_addr;
               w_mem_wdata = r_tos;
               w_nxt_index = r_index - 1'b1;
               // The new top may be the slot just written this cycle.
               w_nxt_tos   = (w_local_addr == w_sec_addr) ? r_tos : r_mem[w_sec_addr];
            end
         end
         default: ;
      endcase

      if (w_over)                          w_nxt_status = ST_OVERFLOW;
      else if (w_under)                    w_nxt_status = ST_UNDERFLOW;
      else if (w_force_none)               w_nxt_status = ST_NONE;
      else if (w_nxt_index == w_nxt_base)  w_nxt_status = ST_EMPTY;
      else                                 w_nxt_status = ST_NONE;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_index  <= '0;
         r_base   <= '0;
         r_fdepth <= '0;
         r_tos    <= '0;
         r_status <= ST_EMPTY;
      end else begin
         r_index  <= w_nxt_index;
         r_base   <= w_nxt_base;
         r_fdepth <= w_nxt_fdepth;
         r_tos    <= w_nxt_tos;
         r_status <= w_nxt_status;
      end
   end

   // NOTE: storage arrays have no reset so they map onto plain RAM.
   always_ff @(posedge clk) begin
      if (w_mem_we) r_mem[w_mem_addr] <= w_mem_wdata;
      if (w_frm_we) r_frames[r_fdepth[FRAMES-1:0]] <= r_base;
   end

   assign tos         = r_tos;
   assign status      = r_status;
   assign index       = r_index;
   assign frame_depth = r_fdepth;

endmodule

// File: tb/tb_frame_stack.sv
// Scoreboard bench for frame_stack: stimulus queues expected outputs,
// a monitor pops and compares one cycle after each op.
module tb_frame_stack;

   localparam int WIDTH  = 32;
   localparam int DEPTH  = 8;
   localparam int FRAMES = 4;

   localparam logic [2:0] NOP = 3'd0, PUSH = 3'd1, POP = 3'd2, REPL = 3'd3,
                          CALL = 3'd4, RET = 3'd5, GET = 3'd6, SET = 3'd7;
   localparam logic [1:0] S_N = 2'd0, S_E = 2'd1, S_U = 2'd2, S_O = 2'd3;

   typedef struct {
      string            name;
      logic [WIDTH-1:0] tos;
      logic [1:0]       st;
      logic [DEPTH:0]   idx;
      logic [FRAMES:0]  fd;
   } exp_t;

   logic              clk = 1'b0;
   logic              reset = 1'b0;
   logic [2:0]        op = NOP;
   logic [WIDTH-1:0]  data = '0;
   logic [DEPTH-1:0]  arg = '0;
   logic              keep = 1'b0;
   logic [WIDTH-1:0]  tos;
   logic [1:0]        status;
   logic [DEPTH:0]    index;
   logic [FRAMES:0]   frame_depth;

   exp_t q[$];
   int   checks = 0;
   int   errors = 0;

   frame_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH), .FRAMES(FRAMES)) dut (
      .clk(clk), .reset(reset), .op(op), .data(data), .arg(arg), .keep(keep),
      .tos(tos), .status(status), .index(index), .frame_depth(frame_depth)
   );

   always #5 clk = ~clk;

   task automatic check(input exp_t e);
      checks++;
      if (tos !== e.tos || status !== e.st || index !== e.idx || frame_depth !== e.fd) begin
         errors++;
         $display("FAIL %s: got tos=%h st=%0d idx=%0d fd=%0d, want tos=%h st=%0d idx=%0d fd=%0d",
                  e.name, tos, status, index, frame_depth, e.tos, e.st, e.idx, e.fd);
      end
   endtask

   // Monitor: outputs for the op sampled at a posedge are valid just after it.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (q.size() > 0) check(q.pop_front());
      end
   end

   task automatic step(input logic [2:0] o, input logic [WIDTH-1:0] d,
                       input logic [DEPTH-1:0] a, input logic k, input string nm,
                       input logic [WIDTH-1:0] et, input logic [1:0] es,
                       input int ei, input int ef);
      exp_t e;
      @(negedge clk);
      op = o; data = d; arg = a; keep = k;
      e.name = nm; e.tos = et; e.st = es;
      e.idx = (DEPTH+1)'(ei); e.fd = (FRAMES+1)'(ef);
      q.push_back(e);
   endtask

   // Reset asserted between edges; outputs must clear without a clock.
   task automatic do_reset(input string nm);
      exp_t e;
      @(posedge clk);
      #2;
      op = NOP;
      reset = 1'b1;
      #1;
      e.name = nm; e.tos = '0; e.st = S_E; e.idx = '0; e.fd = '0;
      check(e);
      @(negedge clk);
      reset = 1'b0;
   endtask

   initial begin
      exp_t e0;
      #1 reset = 1'b1;
      #2;
      e0.name = "reset_init"; e0.tos = '0; e0.st = S_E; e0.idx = '0; e0.fd = '0;
      check(e0);
      @(negedge clk);
      reset = 1'b0;

      // Basic push/pop, SET whose target is the new top, underflow at base 0.
      step(PUSH, 32'h11, 0, 0, "push11",     32'h11, S_N, 1, 0);
      step(PUSH, 32'h22, 0, 0, "push22",     32'h22, S_N, 2, 0);
      step(PUSH, 32'h33, 0, 0, "push33",     32'h33, S_N, 3, 0);
      step(POP,  0,      0, 0, "pop1",       32'h22, S_N, 2, 0);
      step(PUSH, 32'h33, 0, 0, "push33b",    32'h33, S_N, 3, 0);
      step(SET,  0,      1, 0, "set_fwd",    32'h33, S_N, 2, 0);
      step(POP,  0,      0, 0, "pop2",       32'h11, S_N, 1, 0);
      step(POP,  0,      0, 0, "pop_empty",  32'h11, S_E, 0, 0);
      step(POP,  0,      0, 0, "pop_under",  32'h11, S_U, 0, 0);
      step(REPL, 32'h5,  0, 0, "repl_under", 32'h11, S_U, 0, 0);
      step(NOP,  0,      0, 0, "nop_empty",  32'h11, S_E, 0, 0);
      do_reset("reset_a");

      // Fill to capacity, overflow, replace at full.
      for (int i = 0; i < 2**DEPTH; i++)
         step(PUSH, WIDTH'(32'h100 + i), 0, 0, "fill", WIDTH'(32'h100 + i), S_N, i + 1, 0);
      step(PUSH, 32'hFF, 0, 0, "push_over", 32'h1FF, S_O, 256, 0);
      step(REPL, 32'hAA, 0, 0, "repl_full", 32'hAA,  S_N, 256, 0);
      step(GET,  0,      0, 0, "get_over",  32'hAA,  S_O, 256, 0);
      step(POP,  0,      0, 0, "pop_full",  32'h1FE, S_N, 255, 0);
      do_reset("reset_b");

      // Frame with base 1: locals, SET, underflow against base, RETURN keep=0.
      step(PUSH, 32'h1, 0, 0, "f_push1",   32'h1, S_N, 1, 0);
      step(PUSH, 32'h5, 0, 0, "f_push5",   32'h5, S_N, 2, 0);
      step(PUSH, 32'h7, 0, 0, "f_push7",   32'h7, S_N, 3, 0);
      step(CALL, 0,     2, 0, "f_call2",   32'h7, S_N, 3, 1);
      step(GET,  0,     0, 0, "f_get0",    32'h5, S_N, 4, 1);
      step(GET,  0,     1, 0, "f_get1",    32'h7, S_N, 5, 1);
      step(GET,  0,     4, 0, "f_get_oob", 32'h7, S_U, 5, 1);
      step(SET,  0,     0, 0, "f_set0",    32'h5, S_N, 4, 1);
      step(POP,  0,     0, 0, "f_pop_a",   32'h7, S_N, 3, 1);
      step(POP,  0,     0, 0, "f_pop_b",   32'h7, S_N, 2, 1);
      step(POP,  0,     0, 0, "f_pop_e",   32'h7, S_E, 1, 1);
      step(POP,  0,     0, 0, "f_pop_u",   32'h7, S_U, 1, 1);
      step(SET,  0,     0, 0, "f_set_u",   32'h7, S_U, 1, 1);
      step(RET,  0,     0, 1, "f_retk_u",  32'h7, S_U, 1, 1);
      step(RET,  0,     0, 0, "f_ret0",    32'h1, S_N, 1, 0);
      do_reset("reset_c");

      // Empty frame, RETURN keep=1 carries the top into the caller.
      step(PUSH, 32'h1, 0, 0, "k_push1",   32'h1, S_N, 1, 0);
      step(CALL, 0,     0, 0, "k_call0",   32'h1, S_E, 1, 1);
      step(PUSH, 32'h9, 0, 0, "k_push9",   32'h9, S_N, 2, 1);
      step(RET,  0,     0, 1, "k_ret1",    32'h9, S_N, 2, 0);
      step(POP,  0,     0, 0, "k_pop",     32'h1, S_N, 1, 0);
      step(CALL, 0,     2, 0, "k_call_u",  32'h1, S_U, 1, 0);
      do_reset("reset_d");

      // Error ops on the frame stack.
      step(RET,  0, 0, 0, "e_ret_u", 32'h0, S_U, 0, 0);
      for (int i = 1; i <= 2**FRAMES; i++)
         step(CALL, 0, 0, 0, "e_call", 32'h0, S_E, 0, i);
      step(CALL, 0,     0, 0, "e_call_over", 32'h0, S_O, 0, 16);
      step(GET,  0,     0, 0, "e_get_u0",    32'h0, S_U, 0, 16);
      step(PUSH, 32'h3, 0, 0, "e_push3",     32'h3, S_N, 1, 16);
      step(GET,  0,     1, 0, "e_get_u1",    32'h3, S_U, 1, 16);
      step(GET,  0,     0, 0, "e_get0",      32'h3, S_N, 2, 16);
      step(RET,  0,     0, 0, "e_ret0",      32'h3, S_E, 0, 15);
      do_reset("reset_e");

      // Build index 5 / frame_depth 2, then reset mid-sequence.
      step(PUSH, 32'hA1, 0, 0, "m_push1", 32'hA1, S_N, 1, 0);
      step(PUSH, 32'hA2, 0, 0, "m_push2", 32'hA2, S_N, 2, 0);
      step(PUSH, 32'hA3, 0, 0, "m_push3", 32'hA3, S_N, 3, 0);
      step(CALL, 0,      0, 0, "m_call1", 32'hA3, S_E, 3, 1);
      step(PUSH, 32'hA4, 0, 0, "m_push4", 32'hA4, S_N, 4, 1);
      step(CALL, 0,      0, 0, "m_call2", 32'hA4, S_E, 4, 2);
      step(PUSH, 32'hA5, 0, 0, "m_push5", 32'hA5, S_N, 5, 2);
      do_reset("reset_mid");
      step(PUSH, 32'h44, 0, 0, "m_push44", 32'h44, S_N, 1, 0);

      @(negedge clk);
      op = NOP;
      repeat (3) @(posedge clk);
      #2;
      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL drain: got %0d pending, want 0", q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
